// File: rtl/wb_arbiter.sv
// Write-back arbiter: assigns the scalar and vector register-file ports each cycle,
// parks conflicting vector results in a one-entry buffer and throttles vector issue on scalar starvation.
module wb_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scalar_pipeline_we,
  input  logic [3:0] scalar_pipeline_mask,
  input  logic       vector_pipeline_we,
  input  logic [3:0] vector_pipeline_mask,
  output logic       scalar_we_out,
  output logic [3:0] scalar_mask_out,
  output logic       scalar_stall,
  output logic       register_wb_sel,
  output logic       vector_wb_sel,
  output logic       buffer_register_sel,
  output logic       buffer_vector_sel,
  output logic       buffer_register,
  output logic       buffer_vector,
  output logic       vector_issue_hold
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) return v;
    return v + CNT_W'(1);
  endfunction

  logic             s_reg, s_vec, v_reg, v_vec;
  logic             s_reg_e, s_vec_e;
  logic             capture;
  logic             pend_reg_p1, pend_vec_p1;
  logic [CNT_W-1:0] starve_cnt_p1;
  logic [CNT_W-1:0] starve_cnt_nxt;

  // Stage p0: request decode and port resolution against the buffered entry
  always_comb begin
    s_reg = scalar_pipeline_we;
    s_vec = |scalar_pipeline_mask;
    v_reg = vector_pipeline_we;
    v_vec = |vector_pipeline_mask;

    // A pending entry owns its ports outright, so the scalar side yields whole.
    scalar_stall = (s_reg & pend_reg_p1) | (s_vec & pend_vec_p1);
    s_reg_e      = s_reg & ~scalar_stall;
    s_vec_e      = s_vec & ~scalar_stall;

    // Any lost port sends the entire live vector result to the buffer.
    capture = (v_reg & (pend_reg_p1 | s_reg_e)) | (v_vec & (pend_vec_p1 | s_vec_e));

    scalar_we_out       = s_reg_e;
    scalar_mask_out     = scalar_stall ? 4'b0000 : scalar_pipeline_mask;
    buffer_register     = capture;
    buffer_vector       = capture;
    register_wb_sel     = pend_reg_p1 | (v_reg & ~capture);
    buffer_register_sel = pend_reg_p1;
    vector_wb_sel       = pend_vec_p1 | (v_vec & ~capture);
    buffer_vector_sel   = pend_vec_p1;
  end

  always_comb begin
    starve_cnt_nxt = starve_cnt_p1;
    if (scalar_stall)
      starve_cnt_nxt = sat_inc(starve_cnt_p1);
    else if (s_reg | s_vec)
      starve_cnt_nxt = '0;
  end

  // Stage p1: buffer occupancy and starvation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_reg_p1   <= 1'b0;
      pend_vec_p1   <= 1'b0;
      starve_cnt_p1 <= '0;
    end else begin
      pend_reg_p1   <= capture & v_reg;
      pend_vec_p1   <= capture & v_vec;
      starve_cnt_p1 <= starve_cnt_nxt;
    end
  end

  assign vector_issue_hold = (starve_cnt_p1 == CNT_MAX);

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: port-ownership reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with sporadic resets.
module tb_wb_arbiter;
  localparam int STARVE_MAX = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       s_we = 1'b0, v_we = 1'b0;
  logic [3:0] s_mask = 4'h0, v_mask = 4'h0;

  logic       scalar_we_out, scalar_stall, register_wb_sel, vector_wb_sel;
  logic [3:0] scalar_mask_out;
  logic       buffer_register_sel, buffer_vector_sel, buffer_register, buffer_vector;
  logic       vector_issue_hold;

  int checks = 0;
  int errors = 0;

  wb_arbiter #(.STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .scalar_pipeline_we(s_we), .scalar_pipeline_mask(s_mask),
    .vector_pipeline_we(v_we), .vector_pipeline_mask(v_mask),
    .scalar_we_out(scalar_we_out), .scalar_mask_out(scalar_mask_out),
    .scalar_stall(scalar_stall), .register_wb_sel(register_wb_sel),
    .vector_wb_sel(vector_wb_sel), .buffer_register_sel(buffer_register_sel),
    .buffer_vector_sel(buffer_vector_sel), .buffer_register(buffer_register),
    .buffer_vector(buffer_vector), .vector_issue_hold(vector_issue_hold)
  );

  always #5 clk = ~clk;

  // Packed view: {we, mask[3:0], stall, reg_sel, vec_sel, breg_sel, bvec_sel, breg, bvec, hold}
  function automatic logic [12:0] dut_view();
    return {scalar_we_out, scalar_mask_out, scalar_stall, register_wb_sel, vector_wb_sel,
            buffer_register_sel, buffer_vector_sel, buffer_register, buffer_vector,
            vector_issue_hold};
  endfunction

  // Reference model: the buffered entry, plus the length of the current run of stalled cycles.
  typedef enum int {NONE, BUF, SCALAR, LIVE} owner_t;
  bit m_buf_reg = 0, m_buf_vec = 0;
  int m_run = 0;
  bit n_buf_reg = 0, n_buf_vec = 0;
  int n_run = 0;
  bit armed = 0;

  always @(posedge clk) begin
    if (rst) armed <= 1'b1;
    m_buf_reg <= n_buf_reg;
    m_buf_vec <= n_buf_vec;
    m_run     <= n_run;
  end

  always @(negedge clk) begin
    bit wants_reg, wants_vec, v_wants_reg, v_wants_vec, stall, to_buffer;
    owner_t own_reg, own_vec;
    logic [12:0] exp_v, act_v;
    wants_reg   = s_we;
    wants_vec   = (s_mask != 0);
    v_wants_reg = v_we;
    v_wants_vec = (v_mask != 0);
    // The buffer claims its ports first; scalar gets everything it needs or nothing.
    stall   = (wants_reg && m_buf_reg) || (wants_vec && m_buf_vec);
    own_reg = m_buf_reg ? BUF : (wants_reg && !stall) ? SCALAR : NONE;
    own_vec = m_buf_vec ? BUF : (wants_vec && !stall) ? SCALAR : NONE;
    to_buffer = (v_wants_reg && own_reg != NONE) || (v_wants_vec && own_vec != NONE);
    if (!to_buffer) begin
      if (v_wants_reg) own_reg = LIVE;
      if (v_wants_vec) own_vec = LIVE;
    end
    exp_v = {own_reg == SCALAR, stall ? 4'h0 : s_mask, stall,
             own_reg == BUF || own_reg == LIVE, own_vec == BUF || own_vec == LIVE,
             own_reg == BUF, own_vec == BUF, to_buffer, to_buffer, m_run >= STARVE_MAX};
    act_v = dut_view();
    if (armed) begin
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL model_cycle t=%0t: got %b expected %b", $time, act_v, exp_v);
      end
    end
    if (rst) begin
      n_buf_reg = 0; n_buf_vec = 0; n_run = 0;
    end else begin
      n_buf_reg = to_buffer && v_wants_reg;
      n_buf_vec = to_buffer && v_wants_vec;
      if (stall) n_run = m_run + 1;
      else if (wants_reg || wants_vec) n_run = 0;
      else n_run = m_run;
    end
  end

  task automatic chk(input string name, input logic [12:0] act, input logic [12:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp_v);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp_v);
    end
  endtask

  // Apply inputs just after a rising edge; the caller checks at the following falling edge.
  task automatic drive(input logic r, input logic swe, input logic [3:0] sm,
                       input logic vwe, input logic [3:0] vm);
    @(posedge clk); #1;
    rst = r; s_we = swe; s_mask = sm; v_we = vwe; v_mask = vm;
    @(negedge clk);
  endtask

  initial begin
    // Reset held two cycles with every request active
    rst = 1'b1; s_we = 1'b1; s_mask = 4'hF; v_we = 1'b1; v_mask = 4'hF;
    @(negedge clk);
    drive(1, 1, 4'hF, 1, 4'hF);
    drive(0, 0, 4'h0, 0, 4'h0);
    chk("reset_idle", dut_view(), 13'b0);
    drive(0, 0, 4'h0, 0, 4'h0);
    chk("reset_no_drain", dut_view(), 13'b0);

    // No conflict: scalar on register port, vector on vector port
    drive(0, 1, 4'h0, 0, 4'hF);
    chk1("nc_vector_wb_sel", vector_wb_sel, 1'b1);
    chk1("nc_buffer_vector_sel", buffer_vector_sel, 1'b0);
    chk1("nc_register_wb_sel", register_wb_sel, 1'b0);
    chk1("nc_capture", buffer_register, 1'b0);
    chk1("nc_stall", scalar_stall, 1'b0);
    chk1("nc_scalar_we_out", scalar_we_out, 1'b1);

    // Conflict capture then drain
    drive(0, 1, 4'h0, 1, 4'h0);
    chk1("cap_register_wb_sel", register_wb_sel, 1'b0);
    chk1("cap_scalar_we_out", scalar_we_out, 1'b1);
    chk1("cap_buffer_register", buffer_register, 1'b1);
    chk1("cap_buffer_vector", buffer_vector, 1'b1);
    drive(0, 0, 4'h0, 0, 4'h0);
    chk1("drain_register_wb_sel", register_wb_sel, 1'b1);
    chk1("drain_buffer_register_sel", buffer_register_sel, 1'b1);
    chk1("drain_vector_wb_sel", vector_wb_sel, 1'b0);

    // Scalar stall behind a pending register write
    drive(0, 1, 4'h0, 1, 4'h0);
    drive(0, 1, 4'h0, 0, 4'h0);
    chk1("stall_scalar_stall", scalar_stall, 1'b1);
    chk1("stall_scalar_we_out", scalar_we_out, 1'b0);
    chk1("stall_register_wb_sel", register_wb_sel, 1'b1);
    drive(0, 1, 4'h0, 0, 4'h0);
    chk1("after_stall_we_out", scalar_we_out, 1'b1);
    chk1("after_stall_stall", scalar_stall, 1'b0);

    // Starvation: cycle 0 captures, cycles 1..4 stall, hold from cycle 5
    drive(0, 0, 4'h0, 0, 4'h0);
    for (int c = 0; c <= 6; c++) begin
      drive(0, 1, 4'h0, 1, 4'h0);
      chk1($sformatf("starve_hold_c%0d", c), vector_issue_hold, c >= 5);
      chk1($sformatf("starve_stall_c%0d", c), scalar_stall, c >= 1);
    end
    drive(0, 1, 4'h0, 0, 4'h0);
    chk1("starve_last_drain_stall", scalar_stall, 1'b1);
    drive(0, 1, 4'h0, 0, 4'h0);
    chk1("starve_scalar_writes", scalar_we_out, 1'b1);
    chk1("starve_hold_still", vector_issue_hold, 1'b1);
    drive(0, 0, 4'h0, 0, 4'h0);
    chk1("starve_hold_released", vector_issue_hold, 1'b0);

    // Reset right after a capture discards the buffered entry
    drive(0, 1, 4'h0, 1, 4'h0);
    drive(1, 0, 4'h0, 0, 4'h0);
    drive(0, 0, 4'h0, 0, 4'h0);
    chk1("rst_mid_register_wb_sel", register_wb_sel, 1'b0);
    chk1("rst_mid_buffer_register_sel", buffer_register_sel, 1'b0);
    chk("rst_mid_all_zero", dut_view(), 13'b0);

    // Randomized traffic, biased toward conflicts, with sporadic resets
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] sm, vm;
      sm = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      vm = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      drive($urandom_range(0, 60) == 0, 1'($urandom), sm, ($urandom_range(0, 3) != 0), vm);
    end

    drive(0, 0, 4'h0, 0, 4'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
